// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation scheduler: FILL -> IRRIGATE -> CLEAN per zone, with a
// seconds prescaler, per-phase countdown, wet-soil early stop and pesticide interlock.
module irrigation_zone_scheduler #(
   parameter int ZONES       = 4,
   parameter int TICK_CYCLES = 50_000_000,
   parameter int FILL_S      = 5,
   parameter int SPRINK_S    = 30,
   parameter int DRIP_S      = 60,
   parameter int CLEAN_S     = 3,
   parameter int TW          = 8,
   localparam int ZW         = $clog2(ZONES)
) (
   input  logic             clk_50mhz,
   input  logic             init_pulse,
   input  logic             enable_i,
   input  logic [ZONES-1:0] soil_dry_i,
   input  logic             air_dry_i,
   input  logic             temp_high_i,
   input  logic             pesticide_ok_i,
   output logic [1:0]       state_o,
   output logic [1:0]       mode_o,
   output logic [ZW-1:0]    zone_idx_o,
   output logic [ZONES-1:0] zone_valve_o,
   output logic [TW-1:0]    remaining_s_o,
   output logic             cycle_done_o,
   output logic             alert_np_o
);

   localparam int PW = $clog2(TICK_CYCLES);

   localparam logic [1:0] M_NONE   = 2'b00;
   localparam logic [1:0] M_SPRINK = 2'b01;
   localparam logic [1:0] M_DRIP   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_FILL     = 2'b01,
      S_IRRIGATE = 2'b10,
      S_CLEAN    = 2'b11
   } state_t;

   state_t          state, state_n;
   logic [1:0]      mode, mode_n;
   logic [ZW-1:0]   zone, zone_n;
   logic [ZW-1:0]   ptr, ptr_n;
   logic [TW-1:0]   rem, rem_n;
   logic [PW-1:0]   presc, presc_n;
   logic            alert, alert_n;
   logic            done, done_n;
   logic            tick;
   logic            found;
   logic [ZW-1:0]   pick;
   logic [ZW-1:0]   cand;

   // First dry zone at or after ptr, wrapping past the last zone.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = '0;
      for (int i = 0; i < ZONES; i++) begin
         cand = ZW'((int'(ptr) + i) % ZONES);
         if (!found && soil_dry_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign tick = (presc == PW'(TICK_CYCLES - 1));

   always_ff @(posedge clk_50mhz) begin
      if (init_pulse) begin
         state <= S_IDLE;
         mode  <= M_NONE;
         zone  <= '0;
         ptr   <= '0;
         rem   <= '0;
         presc <= '0;
         alert <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         mode  <= mode_n;
         zone  <= zone_n;
         ptr   <= ptr_n;
         rem   <= rem_n;
         presc <= presc_n;
         alert <= alert_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      mode_n  = mode;
      zone_n  = zone;
      ptr_n   = ptr;
      rem_n   = rem;
      presc_n = presc;
      alert_n = alert;
      done_n  = 1'b0;

      if (state != S_IDLE) presc_n = tick ? '0 : presc + 1'b1;

      case (state)
         S_IDLE: begin
            if (alert && pesticide_ok_i) alert_n = 1'b0;
            if (enable_i && found) begin
               if (!pesticide_ok_i) begin
                  alert_n = 1'b1;
               end else begin
                  state_n = S_FILL;
                  zone_n  = pick;
                  mode_n  = (air_dry_i && !temp_high_i) ? M_SPRINK : M_DRIP;
                  rem_n   = TW'(FILL_S);
                  presc_n = '0;
               end
            end
         end
         S_FILL: begin
            // Losing pesticide before water flows aborts without advancing ptr.
            if (!pesticide_ok_i) begin
               state_n = S_IDLE;
               alert_n = 1'b1;
               mode_n  = M_NONE;
               rem_n   = '0;
               presc_n = '0;
            end else if (tick) begin
               if (rem == TW'(1)) begin
                  state_n = S_IRRIGATE;
                  rem_n   = (mode == M_SPRINK) ? TW'(SPRINK_S) : TW'(DRIP_S);
                  presc_n = '0;
               end else begin
                  rem_n = rem - 1'b1;
               end
            end
         end
         S_IRRIGATE: begin
            if (!soil_dry_i[zone] || (tick && rem == TW'(1))) begin
               state_n = S_CLEAN;
               rem_n   = TW'(CLEAN_S);
               presc_n = '0;
            end else if (tick) begin
               rem_n = rem - 1'b1;
            end
         end
         S_CLEAN: begin
            if (tick) begin
               if (rem == TW'(1)) begin
                  state_n = S_IDLE;
                  done_n  = 1'b1;
                  mode_n  = M_NONE;
                  rem_n   = '0;
                  presc_n = '0;
                  ptr_n   = (zone == ZW'(ZONES - 1)) ? '0 : zone + 1'b1;
               end else begin
                  rem_n = rem - 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      zone_valve_o = '0;
      if (state == S_IRRIGATE) zone_valve_o[zone] = 1'b1;
   end

   assign state_o       = state;
   assign mode_o        = mode;
   assign zone_idx_o    = zone;
   assign remaining_s_o = rem;
   assign cycle_done_o  = done;
   assign alert_np_o    = alert;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler with short phase lengths
// (ZONES=4, TICK_CYCLES=4, FILL_S=2, SPRINK_S=5, DRIP_S=3, CLEAN_S=2, TW=4).
module tb_irrigation_zone_scheduler;

   logic       clk_50mhz = 1'b0;
   logic       init_pulse;
   logic       enable_i;
   logic [3:0] soil_dry_i;
   logic       air_dry_i;
   logic       temp_high_i;
   logic       pesticide_ok_i;
   logic [1:0] state_o;
   logic [1:0] mode_o;
   logic [1:0] zone_idx_o;
   logic [3:0] zone_valve_o;
   logic [3:0] remaining_s_o;
   logic       cycle_done_o;
   logic       alert_np_o;

   int n_cmp = 0;
   int n_err = 0;

   irrigation_zone_scheduler #(
      .ZONES(4), .TICK_CYCLES(4), .FILL_S(2), .SPRINK_S(5),
      .DRIP_S(3), .CLEAN_S(2), .TW(4)
   ) dut (
      .clk_50mhz     (clk_50mhz),
      .init_pulse    (init_pulse),
      .enable_i      (enable_i),
      .soil_dry_i    (soil_dry_i),
      .air_dry_i     (air_dry_i),
      .temp_high_i   (temp_high_i),
      .pesticide_ok_i(pesticide_ok_i),
      .state_o       (state_o),
      .mode_o        (mode_o),
      .zone_idx_o    (zone_idx_o),
      .zone_valve_o  (zone_valve_o),
      .remaining_s_o (remaining_s_o),
      .cycle_done_o  (cycle_done_o),
      .alert_np_o    (alert_np_o)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   task automatic step(input int n);
      for (int k = 0; k < n; k++) @(posedge clk_50mhz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, 32'(state_o), 0);
      chk({tag, "_mode"}, 32'(mode_o), 0);
      chk({tag, "_zone"}, 32'(zone_idx_o), 0);
      chk({tag, "_valve"}, 32'(zone_valve_o), 0);
      chk({tag, "_rem"}, 32'(remaining_s_o), 0);
      chk({tag, "_done"}, 32'(cycle_done_o), 0);
      chk({tag, "_alert"}, 32'(alert_np_o), 0);
   endtask

   initial begin
      init_pulse = 1'b1; enable_i = 1'b0; soil_dry_i = 4'b0000;
      air_dry_i = 1'b0; temp_high_i = 1'b0; pesticide_ok_i = 1'b1;
      step(2);
      chk_reset("rst0");

      // Basic sprinkler cycle on zone 1
      init_pulse = 1'b0; enable_i = 1'b1; soil_dry_i = 4'b0010; air_dry_i = 1'b1;
      step(1);
      chk("b_start_state", 32'(state_o), 1);
      chk("b_start_zone", 32'(zone_idx_o), 1);
      chk("b_start_mode", 32'(mode_o), 1);
      chk("b_start_rem", 32'(remaining_s_o), 2);
      chk("b_start_valve", 32'(zone_valve_o), 0);
      step(7);
      chk("b_fill_last_state", 32'(state_o), 1);
      chk("b_fill_last_rem", 32'(remaining_s_o), 1);
      step(1);
      chk("b_irr_state", 32'(state_o), 2);
      chk("b_irr_rem", 32'(remaining_s_o), 5);
      chk("b_irr_valve", 32'(zone_valve_o), 4'b0010);
      chk("b_irr_mode", 32'(mode_o), 1);
      step(19);
      chk("b_irr_last_state", 32'(state_o), 2);
      chk("b_irr_last_rem", 32'(remaining_s_o), 1);
      step(1);
      chk("b_clean_state", 32'(state_o), 3);
      chk("b_clean_rem", 32'(remaining_s_o), 2);
      chk("b_clean_valve", 32'(zone_valve_o), 0);
      step(7);
      chk("b_clean_last_state", 32'(state_o), 3);
      chk("b_clean_last_done", 32'(cycle_done_o), 0);
      step(1);
      chk("b_idle_state", 32'(state_o), 0);
      chk("b_idle_done", 32'(cycle_done_o), 1);
      chk("b_idle_zone", 32'(zone_idx_o), 1);
      chk("b_idle_mode", 32'(mode_o), 0);
      chk("b_idle_rem", 32'(remaining_s_o), 0);
      enable_i = 1'b0;
      step(1);
      chk("b_done_pulse_end", 32'(cycle_done_o), 0);
      chk("b_hold_idle", 32'(state_o), 0);

      // ptr advanced to 2; then pesticide interlock during FILL
      enable_i = 1'b1; soil_dry_i = 4'b1111;
      step(1);
      chk("p_start_state", 32'(state_o), 1);
      chk("p_start_zone", 32'(zone_idx_o), 2);
      pesticide_ok_i = 1'b0;
      step(1);
      chk("p_abort_state", 32'(state_o), 0);
      chk("p_abort_alert", 32'(alert_np_o), 1);
      chk("p_abort_valve", 32'(zone_valve_o), 0);
      chk("p_abort_mode", 32'(mode_o), 0);
      chk("p_abort_zone", 32'(zone_idx_o), 2);
      step(1);
      chk("p_blocked_state", 32'(state_o), 0);
      chk("p_blocked_alert", 32'(alert_np_o), 1);
      pesticide_ok_i = 1'b1;
      step(1);
      chk("p_restart_alert", 32'(alert_np_o), 0);
      chk("p_restart_state", 32'(state_o), 1);
      chk("p_restart_zone", 32'(zone_idx_o), 2);
      step(8);
      chk("p_irr_state", 32'(state_o), 2);
      chk("p_irr_valve", 32'(zone_valve_o), 4'b0100);

      // Reset mid-IRRIGATE
      step(3);
      init_pulse = 1'b1;
      step(1);
      chk_reset("rst_mid");
      init_pulse = 1'b0;
      step(1);
      chk("r_ptr0_state", 32'(state_o), 1);
      chk("r_ptr0_zone", 32'(zone_idx_o), 0);
      chk("r_ptr0_rem", 32'(remaining_s_o), 2);

      // Drip mode and round robin over zones 0 and 3
      init_pulse = 1'b1; soil_dry_i = 4'b1001; temp_high_i = 1'b1;
      step(1);
      chk("d_rst_state", 32'(state_o), 0);
      init_pulse = 1'b0;
      step(1);
      chk("d_start_state", 32'(state_o), 1);
      chk("d_start_zone", 32'(zone_idx_o), 0);
      chk("d_start_mode", 32'(mode_o), 2);
      temp_high_i = 1'b0;
      step(8);
      chk("d_irr_state", 32'(state_o), 2);
      chk("d_irr_rem3", 32'(remaining_s_o), 3);
      chk("d_irr_valve", 32'(zone_valve_o), 4'b0001);
      chk("d_mode_frozen", 32'(mode_o), 2);
      temp_high_i = 1'b1;
      step(4);
      chk("d_irr_rem2", 32'(remaining_s_o), 2);
      step(4);
      chk("d_irr_rem1", 32'(remaining_s_o), 1);
      step(3);
      chk("d_irr_last_state", 32'(state_o), 2);
      step(1);
      chk("d_clean_state", 32'(state_o), 3);
      step(8);
      chk("d_done0", 32'(cycle_done_o), 1);
      chk("d_done0_zone", 32'(zone_idx_o), 0);
      step(1);
      chk("rr_zone3_state", 32'(state_o), 1);
      chk("rr_zone3", 32'(zone_idx_o), 3);
      step(28);
      chk("rr_done3", 32'(cycle_done_o), 1);
      chk("rr_done3_zone", 32'(zone_idx_o), 3);
      step(1);
      chk("rr_wrap_state", 32'(state_o), 1);
      chk("rr_wrap_zone", 32'(zone_idx_o), 0);

      // Early stop on wet soil; enable and pesticide drops ignored mid-cycle
      init_pulse = 1'b1;
      step(1);
      init_pulse = 1'b0; soil_dry_i = 4'b0010; air_dry_i = 1'b1; temp_high_i = 1'b0;
      step(1);
      chk("e_start_zone", 32'(zone_idx_o), 1);
      chk("e_start_mode", 32'(mode_o), 1);
      enable_i = 1'b0;
      step(8);
      chk("e_irr_state", 32'(state_o), 2);
      chk("e_irr_valve", 32'(zone_valve_o), 4'b0010);
      pesticide_ok_i = 1'b0;
      step(5);
      chk("e_irr6_state", 32'(state_o), 2);
      chk("e_irr6_rem", 32'(remaining_s_o), 4);
      soil_dry_i = 4'b0000;
      step(1);
      chk("e_stop_state", 32'(state_o), 3);
      chk("e_stop_rem", 32'(remaining_s_o), 2);
      chk("e_stop_valve", 32'(zone_valve_o), 0);
      step(8);
      chk("e_done", 32'(cycle_done_o), 1);
      chk("e_done_state", 32'(state_o), 0);
      chk("e_no_alert", 32'(alert_np_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
